bitwise_checker: RTL and testbench

BITWISE_CHECKER -- requirements
Module: bitwise_checker

---
 rtl/bitwise_pkg.sv | 20 ++
 rtl/bitwise_ref.sv | 23 ++
 rtl/bitwise_checker.sv | 134 +++++++++++++
 tb/tb_bitwise_checker.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_pkg.sv
// Shared types and constants for the bitwise checker: FSM states and result/op indices.
package bitwise_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NUM_OPS = 6;

    // Op index k selects result y(k+1) and fail_mask bit k.
    localparam int unsigned OP_AND  = 0;
    localparam int unsigned OP_OR   = 1;
    localparam int unsigned OP_XOR  = 2;
    localparam int unsigned OP_XNOR = 3;
    localparam int unsigned OP_NOT  = 4;
    localparam int unsigned OP_ORZ  = 5;

endpackage

// File: rtl/bitwise_ref.sv
// Combinational reference model of the bitwise unit: expected y1..y6 from x, y, z.
module bitwise_ref
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]               x_i,
    input  logic [WIDTH-1:0]               y_i,
    input  logic [WIDTH-1:0]               z_i,
    output logic [NUM_OPS-1:0][WIDTH-1:0]  exp_o
);

    always_comb begin
        exp_o          = '0;
        exp_o[OP_AND]  = x_i & y_i;
        exp_o[OP_OR]   = x_i | y_i;
        exp_o[OP_XOR]  = x_i ^ y_i;
        exp_o[OP_XNOR] = ~(x_i ^ y_i);
        exp_o[OP_NOT]  = ~x_i;
        exp_o[OP_ORZ]  = (x_i & y_i) | z_i;
    end

endmodule

// File: rtl/bitwise_checker.sv
// Checks beats returned by a bitwise unit against bitwise_ref and tallies pass/fail.
// Optional first-failure capture is enabled by defining BITWISE_CHK_FIRST_FAIL_EN.
module bitwise_checker
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_txn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic [WIDTH-1:0]   z,
    input  logic [WIDTH-1:0]   y1,
    input  logic [WIDTH-1:0]   y2,
    input  logic [WIDTH-1:0]   y3,
    input  logic [WIDTH-1:0]   y4,
    input  logic [WIDTH-1:0]   y5,
    input  logic [WIDTH-1:0]   y6,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic [NUM_OPS-1:0] fail_mask
`ifdef BITWISE_CHK_FIRST_FAIL_EN
    ,
    output logic [CNT_W-1:0]   first_fail_idx,
    output logic               first_fail_vld
`endif
);

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             num_q, idx_q, pass_q, fail_q;
    logic [NUM_OPS-1:0]           mask_q;
    logic [NUM_OPS-1:0][WIDTH-1:0] exp_w, got_w;
    logic [NUM_OPS-1:0]           mm_w;
    logic                         start_ok, all_in, accept;

    bitwise_ref #(.WIDTH(WIDTH)) u_ref (
        .x_i   (x),
        .y_i   (y),
        .z_i   (z),
        .exp_o (exp_w)
    );

    assign got_w = {y6, y5, y4, y3, y2, y1};

    always_comb begin
        mm_w = '0;
        for (int unsigned k = 0; k < NUM_OPS; k++) begin
            mm_w[k] = (got_w[k] != exp_w[k]);
        end
    end

    // RUN lingers one cycle after the last beat so the final counts are visible
    // before done; beats offered in that cycle are not counted.
    assign start_ok = start && (state_q != RUN);
    assign all_in   = (idx_q == num_q);
    assign accept   = in_valid && (state_q == RUN) && !all_in;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) state_d = (num_txn != '0) ? RUN : DONE;
                done = (state_q == DONE);
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (all_in) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            idx_q   <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                num_q  <= num_txn;
                idx_q  <= '0;
                pass_q <= '0;
                fail_q <= '0;
                mask_q <= '0;
            end else if (accept) begin
                idx_q <= (&idx_q) ? idx_q : idx_q + 1'b1;
                if (mm_w == '0) begin
                    pass_q <= (&pass_q) ? pass_q : pass_q + 1'b1;
                end else begin
                    fail_q <= (&fail_q) ? fail_q : fail_q + 1'b1;
                    mask_q <= mask_q | mm_w;
                end
            end
        end
    end

    assign pass_cnt  = pass_q;
    assign fail_cnt  = fail_q;
    assign fail_mask = mask_q;

`ifdef BITWISE_CHK_FIRST_FAIL_EN
    logic [CNT_W-1:0] ff_idx_q;
    logic             ff_vld_q;

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            ff_idx_q <= '0;
            ff_vld_q <= 1'b0;
        end else if (accept && (mm_w != '0) && !ff_vld_q) begin
            ff_idx_q <= idx_q;
            ff_vld_q <= 1'b1;
        end
    end

    assign first_fail_idx = ff_idx_q;
    assign first_fail_vld = ff_vld_q;
`endif

endmodule

// File: tb/tb_bitwise_checker.sv
// Self-checking bench for bitwise_checker: reference-model scoreboard plus directed scenarios.
module tb_bitwise_checker;

    logic       clk = 1'b0;
    logic       rst, start, in_valid;
    logic [7:0] num_txn;
    logic [3:0] x, y, z, y1, y2, y3, y4, y5, y6;
    logic       in_ready, busy, done;
    logic [7:0] pass_cnt, fail_cnt;
    logic [5:0] fail_mask;
`ifdef BITWISE_CHK_FIRST_FAIL_EN
    logic [7:0] first_fail_idx;
    logic       first_fail_vld;
`endif

    always #5 clk = ~clk;

    bitwise_checker #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_txn   (num_txn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .z         (z),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .y4        (y4),
        .y5        (y5),
        .y6        (y6),
        .busy      (busy),
        .done      (done),
        .pass_cnt  (pass_cnt),
        .fail_cnt  (fail_cnt),
        .fail_mask (fail_mask)
`ifdef BITWISE_CHK_FIRST_FAIL_EN
        ,
        .first_fail_idx (first_fail_idx),
        .first_fail_vld (first_fail_vld)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] pass;
        logic [7:0] fail;
        logic [5:0] mask;
    } sb_t;
    sb_t sbq[$];

    // Model: 0 = IDLE, 1 = RUN, 2 = DONE
    int         m_state;
    logic [7:0] m_num, m_idx, m_pass, m_fail, m_ffidx;
    logic [5:0] m_mask;
    bit         m_ffv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0][3:0] ref_ops(input logic [3:0] a, input logic [3:0] b,
                                                input logic [3:0] c);
        logic [5:0][3:0] r;
        r[0] = a & b;
        r[1] = a | b;
        r[2] = a ^ b;
        r[3] = ~(a ^ b);
        r[4] = ~a;
        r[5] = (a & b) | c;
        return r;
    endfunction

    task automatic model_clear();
        m_idx  = '0;
        m_pass = '0;
        m_fail = '0;
        m_mask = '0;
        m_ffidx = '0;
        m_ffv  = 1'b0;
    endtask

    // Advances the model by one cycle from the currently driven inputs, clocks
    // the DUT, then compares; count updates come from the scoreboard queue.
    task automatic tick();
        logic [5:0][3:0] got, e;
        logic [5:0]      mm;
        bit              due;
        sb_t             ent;
        got = {y6, y5, y4, y3, y2, y1};
        e   = ref_ops(x, y, z);
        for (int k = 0; k < 6; k++) mm[k] = (got[k] != e[k]);
        due = 1'b0;
        if (rst) begin
            m_state = 0;
            m_num   = '0;
            model_clear();
        end else if (m_state != 1 && start) begin
            model_clear();
            m_num   = num_txn;
            m_state = (num_txn != 0) ? 1 : 2;
        end else if (m_state == 1) begin
            if (m_idx == m_num) begin
                m_state = 2;
            end else if (in_valid) begin
                if (mm == 6'b0) begin
                    if (m_pass != 8'hFF) m_pass = m_pass + 8'd1;
                end else begin
                    if (m_fail != 8'hFF) m_fail = m_fail + 8'd1;
                    m_mask = m_mask | mm;
                    if (!m_ffv) begin
                        m_ffv   = 1'b1;
                        m_ffidx = m_idx;
                    end
                end
                m_idx = m_idx + 8'd1;
                sbq.push_back('{m_pass, m_fail, m_mask});
                due = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("in_ready", in_ready, (m_state == 1));
        check("busy", busy, (m_state == 1));
        check("done", done, (m_state == 2));
        if (due && sbq.size() > 0) begin
            ent = sbq.pop_front();
            check("pass_cnt", pass_cnt, ent.pass);
            check("fail_cnt", fail_cnt, ent.fail);
            check("fail_mask", fail_mask, ent.mask);
        end else begin
            check("pass_cnt_hold", pass_cnt, m_pass);
            check("fail_cnt_hold", fail_cnt, m_fail);
            check("fail_mask_hold", fail_mask, m_mask);
        end
`ifdef BITWISE_CHK_FIRST_FAIL_EN
        check("first_fail_vld", first_fail_vld, m_ffv);
        check("first_fail_idx", first_fail_idx, m_ffidx);
`endif
    endtask

    task automatic beat_raw(input bit v, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [5:0][3:0] r);
        in_valid = v;
        x = a;
        y = b;
        z = c;
        {y6, y5, y4, y3, y2, y1} = r;
        tick();
    endtask

    // Random operands; results corrupted in the ops selected by flip.
    task automatic rbeat(input bit v, input logic [5:0] flip);
        logic [3:0]      a, b, c;
        logic [5:0][3:0] r;
        a = 4'($urandom);
        b = 4'($urandom);
        c = 4'($urandom);
        r = ref_ops(a, b, c);
        for (int k = 0; k < 6; k++)
            if (flip[k]) r[k] = r[k] ^ 4'(1 << $urandom_range(0, 3));
        beat_raw(v, a, b, c, r);
    endtask

    task automatic do_start(input logic [7:0] n);
        start    = 1'b1;
        num_txn  = n;
        in_valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    logic [5:0][3:0] good_r, bad_r;

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_txn = '0;
        x = '0; y = '0; z = '0;
        {y6, y5, y4, y3, y2, y1} = '0;
        m_state = 0; m_num = '0;
        model_clear();
        tick();
        tick();
        check("rst_pass", pass_cnt, 8'd0);
        check("rst_fail", fail_cnt, 8'd0);
        rst = 1'b0;
        tick();

        // Single passing beat with the published vector.
        good_r = {4'b0001, 4'b0110, 4'b0011, 4'b1100, 4'b1101, 4'b0001};
        do_start(8'd1);
        beat_raw(1'b1, 4'b1001, 4'b0101, 4'b0000, good_r);
        check("t1_pass", pass_cnt, 8'd1);
        check("t1_fail", fail_cnt, 8'd0);
        check("t1_done_early", done, 1'b0);
        in_valid = 1'b0;
        tick();
        check("t1_done", done, 1'b1);
        tick();
        check("t1_done_hold", done, 1'b1);

        // Same beat with y3 corrupted.
        bad_r = good_r;
        bad_r[2] = 4'b1101;
        do_start(8'd1);
        beat_raw(1'b1, 4'b1001, 4'b0101, 4'b0000, bad_r);
        check("t2_fail", fail_cnt, 8'd1);
        check("t2_mask", fail_mask, 6'b000100);
`ifdef BITWISE_CHK_FIRST_FAIL_EN
        check("t2_ffidx", first_fail_idx, 8'd0);
        check("t2_ffvld", first_fail_vld, 1'b1);
`endif
        in_valid = 1'b0;
        tick();

        // Gapped valid: three acceptances across five cycles.
        do_start(8'd3);
        rbeat(1'b1, 6'b0);
        rbeat(1'b0, 6'b0);
        rbeat(1'b1, 6'b100000);
        rbeat(1'b0, 6'b0);
        rbeat(1'b1, 6'b0);
        check("t3_pass", pass_cnt, 8'd2);
        check("t3_fail", fail_cnt, 8'd1);
        check("t3_mask", fail_mask, 6'b100000);
        in_valid = 1'b0;
        tick();
        check("t3_done", done, 1'b1);

        // Zero-length run goes straight to DONE.
        do_start(8'd0);
        check("t4_done", done, 1'b1);
        check("t4_ready", in_ready, 1'b0);
        rbeat(1'b1, 6'b0);
        check("t4_pass", pass_cnt, 8'd0);

        // Reset mid-run discards the beat offered in the same cycle.
        do_start(8'd5);
        rbeat(1'b1, 6'b000011);
        rbeat(1'b1, 6'b0);
        rst = 1'b1;
        rbeat(1'b1, 6'b010000);
        rst = 1'b0;
        check("t5_rst_pass", pass_cnt, 8'd0);
        check("t5_rst_fail", fail_cnt, 8'd0);
        check("t5_rst_busy", busy, 1'b0);
        do_start(8'd2);
        rbeat(1'b1, 6'b0);
        rbeat(1'b1, 6'b0);
        in_valid = 1'b0;
        tick();
        check("t5_pass", pass_cnt, 8'd2);
        check("t5_done", done, 1'b1);

        // Mixed random run.
        do_start(8'd20);
        for (int i = 0; i < 200 && m_idx != m_num; i++)
            rbeat(1'($urandom), ($urandom_range(0, 1) != 0) ? 6'($urandom) : 6'b0);
        check("t6_all_in", m_idx, 8'd20);
        in_valid = 1'b0;
        tick();
        check("t6_done", done, 1'b1);

        // 255 failing beats with start pulsed mid-run: ignored, no wrap.
        do_start(8'd255);
        for (int i = 0; i < 255; i++) begin
            if (i == 100) begin
                start   = 1'b1;
                num_txn = 8'd5;
            end
            rbeat(1'b1, 6'($urandom_range(1, 63)));
            start = 1'b0;
        end
        check("t7_fail", fail_cnt, 8'd255);
        check("t7_pass", pass_cnt, 8'd0);
        rbeat(1'b1, 6'b111111);
        check("t7_nowrap", fail_cnt, 8'd255);
        in_valid = 1'b0;
        tick();
        check("t7_done", done, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
